// File: rtl/mux_pkg.sv
// Shared encodings for the N:1 registered scan multiplexer: mode values and
// scan FSM state encoding.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        MANUAL  = 2'd0,
        DWELL   = 2'd1,
        CAPTURE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/mux_nx1_scan_if.sv
// Bus bundle between the N parallel producers / single consumer and the
// mux_nx1_scan block. The master drives channels and controls, the slave is the mux.
interface mux_nx1_scan_if #(
    parameter int N  = 7,
    parameter int W  = 8,
    parameter int DW = 4
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [DW-1:0]  dwell;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;
    logic           sel_err;

    modport master (
        output in_data, in_valid, mode, sel, dwell, out_ready,
        input  out_data, out_ch, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_valid, mode, sel, dwell, out_ready,
        output out_data, out_ch, out_valid, sel_err
    );

endinterface

// File: rtl/mux_nx1_comb.sv
// Combinational indexed lane select over a flattened N*W bus.
// An index at or beyond N yields all zeros.
module mux_nx1_comb #(
    parameter int N = 7,
    parameter int W = 8
) (
    input  logic [N*W-1:0]         data,
    input  logic [$clog2(N)-1:0]   idx,
    output logic [W-1:0]           y
);
    localparam int SW = $clog2(N);

    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SW'(k)) begin
                y = data[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-channel, W-bit registered multiplexer with valid/ready output stage,
// out-of-range select flag and an auto-scan mode with programmable dwell.
//
// state   | meaning
// MANUAL  | output follows sel; scan entry point (ptr/cnt cleared on leaving)
// DWELL   | counting dwell cycles on the current channel
// CAPTURE | loading channel ptr, or stalled waiting for a free output slot
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N  = 7,
    parameter int W  = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_nx1_scan_if.slave bus
);
    localparam int SW  = $clog2(N);
    localparam int SWP = SW + 1;
    localparam logic [SW:0]   N_EXT    = SWP'(N);
    localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);

    scan_state_e   state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d, ptr_next;
    logic [DW-1:0] cnt_q, cnt_d;

    logic [W-1:0]  data_q;
    logic [SW-1:0] ch_q;
    logic          valid_q;
    logic          err_q;

    logic          slot_free;
    logic          sel_ok;
    logic          load;
    logic [W-1:0]  ld_data;
    logic [SW-1:0] ld_ch;
    logic          ld_valid;

    logic [W-1:0]  sel_data, ptr_data;
    logic          sel_vld, ptr_vld;

    mux_nx1_comb #(.N(N), .W(W)) u_sel_data (.data(bus.in_data),  .idx(bus.sel), .y(sel_data));
    mux_nx1_comb #(.N(N), .W(1)) u_sel_vld  (.data(bus.in_valid), .idx(bus.sel), .y(sel_vld));
    mux_nx1_comb #(.N(N), .W(W)) u_ptr_data (.data(bus.in_data),  .idx(ptr_q),   .y(ptr_data));
    mux_nx1_comb #(.N(N), .W(1)) u_ptr_vld  (.data(bus.in_valid), .idx(ptr_q),   .y(ptr_vld));

    assign slot_free = !valid_q || bus.out_ready;
    assign sel_ok    = {1'b0, bus.sel} < N_EXT;
    assign ptr_next  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        ld_data  = '0;
        ld_ch    = '0;
        ld_valid = 1'b0;

        // Manual mode wins in every state, so a mode drop applies manual rules at once.
        if (bus.mode == MODE_MANUAL) begin
            state_d = MANUAL;
            if (slot_free) begin
                load     = 1'b1;
                ld_data  = sel_data;
                ld_ch    = bus.sel;
                ld_valid = sel_ok && sel_vld;
            end
        end else begin
            case (state_q)
                MANUAL: begin
                    state_d = DWELL;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
                DWELL: begin
                    if (cnt_q == bus.dwell) begin
                        cnt_d   = '0;
                        state_d = CAPTURE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!ptr_vld) begin
                        ptr_d   = ptr_next;
                        state_d = DWELL;
                    end else if (slot_free) begin
                        load     = 1'b1;
                        ld_data  = ptr_data;
                        ld_ch    = ptr_q;
                        ld_valid = 1'b1;
                        ptr_d    = ptr_next;
                        state_d  = DWELL;
                    end
                end
                default: state_d = MANUAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= (bus.mode == MODE_MANUAL) && !sel_ok;
            if (load) begin
                data_q  <= ld_data;
                ch_q    <= ld_ch;
                valid_q <= ld_valid;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Self-checking bench for mux_nx1_scan: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural reference model.
module tb_mux_nx1_scan;
    import mux_pkg::*;

    localparam int N  = 7;
    localparam int W  = 8;
    localparam int DW = 4;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_nx1_scan_if #(.N(N), .W(W), .DW(DW)) bus ();
    mux_nx1_scan    #(.N(N), .W(W), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    int m_data, m_ch;
    bit m_valid, m_err;
    bit in_scan, capturing;
    int ptr, elapsed;

    int bq_ch[$];
    int bq_dat[$];
    int bq_t[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int chan(input int k);
        return int'(bus.in_data[k*W +: W]);
    endfunction

    function automatic bit vld(input int k);
        return (k < N) ? bus.in_valid[k] : 1'b0;
    endfunction

    task automatic model_step();
        int s, dl;
        bit rdy, md, free;
        s   = int'(bus.sel);
        dl  = int'(bus.dwell);
        rdy = bus.out_ready;
        md  = bus.mode;
        if (rst) begin
            m_data = 0; m_ch = 0; m_valid = 0; m_err = 0;
            in_scan = 0; capturing = 0; ptr = 0; elapsed = 0;
            return;
        end
        free  = !m_valid || rdy;
        m_err = (md == MODE_MANUAL) && (s >= N);
        if (m_valid && rdy) m_valid = 0;
        if (md == MODE_MANUAL) begin
            in_scan = 0;
            if (free) begin
                m_ch    = s;
                m_valid = vld(s);
                m_data  = (s < N) ? chan(s) : 0;
            end
        end else if (!in_scan) begin
            in_scan = 1; capturing = 0; ptr = 0; elapsed = 0;
        end else if (!capturing) begin
            if (elapsed == dl) begin
                elapsed   = 0;
                capturing = 1;
            end else begin
                elapsed = (elapsed + 1) % (1 << DW);
            end
        end else if (!vld(ptr)) begin
            ptr       = (ptr + 1) % N;
            capturing = 0;
        end else if (free) begin
            m_ch      = ptr;
            m_data    = chan(ptr);
            m_valid   = 1;
            ptr       = (ptr + 1) % N;
            capturing = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("m_data",  bus.out_data,  m_data);
        chk("m_ch",    bus.out_ch,    m_ch);
        chk("m_valid", bus.out_valid, m_valid);
        chk("m_err",   bus.sel_err,   m_err);
    endtask

    task automatic record(input int n);
        bq_ch.delete(); bq_dat.delete(); bq_t.delete();
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.out_valid && bus.out_ready) begin
                bq_ch.push_back(int'(bus.out_ch));
                bq_dat.push_back(int'(bus.out_data));
                bq_t.push_back(cyc);
            end
        end
    endtask

    task automatic wait_valid(input int ch, input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (bus.out_valid && (ch < 0 || int'(bus.out_ch) == ch)) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit ok, seen24;
        int n3, held_ch, held_dat;

        rst = 1'b1;
        bus.mode = MODE_MANUAL;
        bus.sel = '0;
        bus.dwell = '0;
        bus.out_ready = 1'b1;
        bus.in_valid = '1;
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = 8'(8'h10 + k);
        tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data",  bus.out_data,  0);
        rst = 1'b0;

        // manual select
        bus.in_data[5*W +: W] = 8'hA5;
        bus.sel = 3'd5;
        tick();
        chk("man_data",  bus.out_data,  8'hA5);
        chk("man_ch",    bus.out_ch,    5);
        chk("man_valid", bus.out_valid, 1);
        chk("man_err",   bus.sel_err,   0);

        // out-of-range select
        bus.sel = 3'd7;
        tick();
        chk("oor_err",   bus.sel_err,   1);
        chk("oor_valid", bus.out_valid, 0);
        chk("oor_data",  bus.out_data,  0);
        bus.sel = 3'd2;
        tick();
        chk("oor_clr_err",  bus.sel_err,  0);
        chk("oor_clr_data", bus.out_data, 8'h12);

        // scan, dwell=0, all valid
        bus.in_data[5*W +: W] = 8'h15;
        bus.mode = MODE_SCAN;
        record(20);
        chk("scan_beats", bq_ch.size() >= 8, 1);
        for (int i = 0; i < 8 && i < bq_ch.size(); i++) begin
            chk("scan_ch",  bq_ch[i],  i % N);
            chk("scan_dat", bq_dat[i], 8'h10 + (i % N));
            if (i > 0) chk("scan_gap", bq_t[i] - bq_t[i-1], 2);
        end

        // skip a channel
        bus.in_valid[3] = 1'b0;
        record(24);
        n3 = 0; seen24 = 0;
        for (int i = 0; i < bq_ch.size(); i++) begin
            if (bq_ch[i] == 3) n3++;
            if (i > 0 && bq_ch[i-1] == 2 && bq_ch[i] == 4) seen24 = 1;
        end
        chk("skip_ch3", n3, 0);
        chk("skip_2to4", seen24, 1);
        bus.in_valid[3] = 1'b1;

        // backpressure stall
        wait_valid(-1, 10, ok);
        chk("bp_found", ok, 1);
        held_ch = int'(bus.out_ch);
        held_dat = int'(bus.out_data);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_ch",  bus.out_ch,    held_ch);
            chk("bp_hold_dat", bus.out_data,  held_dat);
            chk("bp_hold_vld", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_next_vld", bus.out_valid, 1);
        chk("bp_next_ch",  bus.out_ch,    (held_ch + 1) % N);

        // reset while stalled at ptr=4
        wait_valid(3, 30, ok);
        chk("rs_found3", ok, 1);
        bus.out_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rs_valid", bus.out_valid, 0);
        chk("rs_data",  bus.out_data,  0);
        chk("rs_ch",    bus.out_ch,    0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        wait_valid(-1, 20, ok);
        chk("rs_resume", ok, 1);
        chk("rs_first_ch", bus.out_ch, 0);

        // dwell=3 period, then mode switch with a held beat
        bus.dwell = 4'd3;
        record(30);
        chk("dw_beats", bq_t.size() >= 4, 1);
        for (int i = 1; i < bq_t.size(); i++) chk("dw_gap", bq_t[i] - bq_t[i-1], 5);
        wait_valid(-1, 10, ok);
        chk("ms_found", ok, 1);
        held_ch = int'(bus.out_ch);
        held_dat = int'(bus.out_data);
        bus.out_ready = 1'b0;
        bus.mode = MODE_MANUAL;
        bus.sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ms_hold_ch",  bus.out_ch,   held_ch);
            chk("ms_hold_dat", bus.out_data, held_dat);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("ms_man_ch",  bus.out_ch,    1);
        chk("ms_man_dat", bus.out_data,  8'h11);
        chk("ms_man_vld", bus.out_valid, 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                bus.in_data[k*W +: W] = 8'($urandom);
                bus.in_valid[k] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 19) == 0) bus.dwell = DW'($urandom_range(0, 5));
            bus.sel = SW'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
Parametrised N-channel, W-bit registered multiplexer. It is the successor to the fixed 7:1 single-bit mux built from 4:1 and 2:1 stages. It adds a registered valid/ready output stage, detection of out-of-range selects, and an auto-scan mode that steps through the channels with a programmable dwell. It sits between N parallel producers, such as sensor or status lanes, and a single downstream consumer.

Parameters:
- N, 7, number of input channels (2..64).
- W, 8, data width per channel.
- DW, 4, width of the dwell-count input.
- SW, $clog2(N) (localparam, not overridable), width of the select and channel-index fields.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  N*W  channel k occupies bits [k*W +: W].
- in_valid  in  N  per-channel data-valid.
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel  in  SW  channel select, used in manual mode only.
- dwell  in  DW  extra cycles to wait on each channel in scan mode.
- out_data  out  W  registered selected data.
- out_ch  out  SW  index of the channel held in out_data.
- out_valid  out  1  out_data/out_ch hold an untaken beat.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- sel_err  out  1  registered flag: manual-mode sel >= N.

Behaviour:
- Reset, taken at the clock edge while rst=1, overrides everything:
  - out_data=0, out_ch=0, out_valid=0, sel_err=0.
  - Scan pointer ptr=0, dwell counter cnt=0, FSM=MANUAL.
  - A reset in mid-scan or mid-stall discards the held beat.
- slot_free = !out_valid || out_ready. The output register loads only when slot_free. Otherwise out_data, out_ch and out_valid hold unchanged until taken.
- FSM states are MANUAL, DWELL and CAPTURE. mode is sampled every cycle.
  - mode=0 in any state: next state is MANUAL.
  - mode=1 in MANUAL: next state is DWELL with ptr=0 and cnt=0.
- MANUAL, when slot_free:
  - out_valid <= (sel<N) && in_valid[sel].
  - out_ch <= sel.
  - out_data <= in_data[sel] if sel<N, else 0.
  - Manual latency is 1 cycle, sel/data to out_data.
- sel_err <= (mode==0) && (sel>=N), updated every cycle regardless of slot_free. It is always 0 in scan mode. Out-of-range sel never produces out_valid=1.
- DWELL:
  - If cnt==dwell, cnt<=0 and go to CAPTURE. Otherwise cnt<=cnt+1.
  - dwell=0 gives exactly 1 DWELL cycle.
  - dwell is sampled live; changing it mid-dwell takes effect on the next compare.
- CAPTURE:
  - in_valid[ptr]==0: skip. Advance ptr, go to DWELL, no load.
  - in_valid[ptr]==1 and slot_free: load out_data=in_data[ptr], out_ch=ptr, out_valid=1. Advance ptr, go to DWELL.
  - in_valid[ptr]==1 and !slot_free: stay in CAPTURE (stall). If in_valid[ptr] drops during the stall, skip as above.
- Pointer wrap: ptr advances N-1 -> 0. No other values are reachable.
- Throughput: with no backpressure and all channels valid, there is one beat per channel every dwell+2 cycles, in order 0,1,…,N-1,0,….
- Switching mode 1->0 does not disturb a held beat. The next load follows MANUAL rules.
- Simultaneous take and load: when out_valid && out_ready and a new load occurs in the same cycle, the new beat replaces the old one. out_valid stays 1 with no bubble.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
  - FSM state encoding: MANUAL=2'd0, DWELL=2'd1, CAPTURE=2'd2.
- One sub-module, mux_nx1_comb (parameters N and W): purely combinational indexed selection over the flattened bus. It returns 0 for an out-of-range index. It is instantiated twice: once on sel with in_data, and once on ptr with in_data. The in_valid lookup uses 1-bit instances, or indexes in_valid directly.
- Scan FSM, counters and output register live in the top module.

Test Plan:
- Manual select: N=7, W=8, mode=0, in_data ch5=8'hA5, in_valid=7'h7F, sel=5, out_ready=1 -> next cycle out_data=8'hA5, out_ch=5, out_valid=1, sel_err=0.
- Out-of-range: sel=7 with N=7 -> next cycle sel_err=1, out_valid=0, out_data=0. Then sel=2 -> sel_err=0 and ch2 data appears.
- Scan: mode=1, dwell=0, all valid, channel k data=8'h10+k, out_ready=1 -> beats 0x10..0x16 with out_ch 0..6, one every 2 cycles, then wrap to ch0 (0x10).
- Skip and backpressure:
  - in_valid[3]=0 -> the ch3 beat is absent; out_ch goes 2 -> 4.
  - out_ready=0 for 5 cycles while out_valid -> out_data/out_ch stable and FSM stalls in CAPTURE. Releasing ready resumes with no lost or duplicated channel.
- Reset mid-scan: rst=1 for 1 cycle during a stall at ptr=4 -> next cycle out_valid=0, out_data=0, out_ch=0. With mode=1 held, the next beat is ch0.
- Mode switch with dwell=3: beat period is 5 cycles. Switch mode 1->0 while out_valid=1, out_ready=0 -> held beat unchanged until taken, then manual sel is honoured.
